rv32c_fetch_aligner: RTL and testbench
======================================

Name: rv32c_fetch_aligner

Overview:
- Fetch-side initiator for the compressed-instruction path.
- Issues word-aligned 32-bit instruction-memory reads and realigns the returned halfwords into a small parcel buffer.
- Presents one instruction per handshake, either a 16-bit compressed parcel or a full 32-bit instruction, with its halfword-aligned PC. A 32-bit instruction may straddle two memory words.
- Sits between the instruction memory port and the compressed-instruction expander / decode stage; consumes branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0200, PC of the first instruction after reset. Bit 0 is ignored.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- imem_req  output  1  read request; held until imem_ack
- imem_addr  output  32  read address; bits [1:0] always 0; stable while imem_req=1
- imem_ack  input  1  read data valid; may assert in the same cycle as imem_req
- imem_rdata  input  32  read data; halfword 0 = bits [15:0]
- redirect  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  32  redirect target; bit 0 ignored
- stall  input  1  downstream not ready
- inst_valid  output  1  inst_out / inst_pc / inst_is_c valid
- inst_out  output  32  32-bit instruction, or {16'h0, parcel} when compressed
- inst_is_c  output  1  head parcel is compressed (bits [1:0] != 2'b11)
- inst_pc  output  32  PC of the presented instruction, bit 0 = 0

Behaviour:
- Clock, reset and reset values: one clock domain (CLK). nRST is asynchronous and active-low. While nRST=0:
  - state=IDLE, halfword count=0, buffer=0
  - fetch_pc = RESET_PC & ~3; inst_pc = RESET_PC & ~1; drop_low = RESET_PC[1]
  - imem_req=0, inst_valid=0, inst_out=0, inst_is_c=0
- Buffer: 3 halfwords (48 bits), count 0..3. Head = oldest halfword.
- Presentation:
  - head[1:0] != 2'b11 and count>=1 -> compressed; inst_valid=1, inst_is_c=1, inst_out = {16'h0, head}.
  - head[1:0] == 2'b11 -> inst_valid=1 only when count>=2; inst_out = {hw1, hw0}, inst_is_c=0.
- Consume: inst_valid & ~stall & ~redirect pops 1 halfword (inst_pc+=2) or 2 halfwords (inst_pc+=4). 32-bit wrap-around of the PC is allowed.
- Fetch FSM:
  - IDLE: imem_req=0. Go to WAIT when the post-consume count <=1.
  - WAIT: imem_req=1, imem_addr=fetch_pc. On imem_ack: append both halfwords, or only the high halfword if drop_low=1, then clear drop_low. fetch_pc += 4; go to IDLE. Only one request is ever outstanding.
  - DISCARD: imem_req=1 with the old address held. On imem_ack: data dropped; go to IDLE.
- Refill rule: append and pop in the same cycle are both applied; count_next = count - popped + appended. A refill is requested only at count<=1, so count never exceeds 3.
- Redirect (takes effect the next cycle; wins over consume and ack in the same cycle):
  - count=0, inst_pc = redirect_pc & ~1, fetch_pc = redirect_pc & ~3, drop_low = redirect_pc[1].
  - If WAIT without ack this cycle -> DISCARD. Otherwise -> IDLE.
  - Redirect while in DISCARD: targets update; stay in DISCARD.
- Latency: after nRST release, imem_req asserts in cycle 1. A same-cycle ack gives inst_valid in cycle 2.
- Outputs are combinational from registered state only; no combinational path from imem_* or stall to inst_*.
- Reset mid-transaction: outstanding request abandoned; imem_req drops asynchronously.

Test Plan:
- Reset with RESET_PC=32'h200; memory returns 32'h0000_4501 (compressed) at 0x200 with zero-wait ack -> imem_req asserts cycle 1 with addr 0x200. In cycle 2, inst_valid=1, inst_is_c=1, inst_out=32'h0000_4501, inst_pc=0x200. Next presentation is hw 0x0000 at pc 0x202.
- Straddle: word 0x200 = 32'h0093_4501, word 0x204 = 32'hxxxx_0010 -> C inst 0x4501 at 0x200. Then 32-bit inst 32'h0010_0093 presented only after the 0x204 ack, at pc 0x202. Next pc = 0x206.
- Redirect to 32'h0000_0306 while a WAIT request is pending (ack delayed 3 cycles) -> FSM enters DISCARD and the stale data is dropped. Then a request to 0x304 is issued; only its upper halfword is presented, at pc 0x306.
- stall=1 held 5 cycles with a full buffer (count=3) -> inst_out and inst_pc stable, no new imem_req. After release, pops proceed in order.
- Same-cycle redirect + imem_ack + consume -> ack data dropped, no pop. Next cycle count=0, inst_valid=0, inst_pc = target.
- Assert nRST low mid-WAIT -> imem_req=0 immediately. After release, the fetch restarts at 0x200.

Source files
------------

// File: rtl/rv32c_fetch_aligner_if.sv
// Fetch aligner bus bundle: instruction-memory read port, redirect input and
// the instruction presentation handshake toward the expander/decode stage.
interface rv32c_fetch_aligner_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic        inst_is_c;
    logic [31:0] inst_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc, stall,
        output inst_valid, inst_out, inst_is_c, inst_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc, stall,
        input  inst_valid, inst_out, inst_is_c, inst_pc
    );
endinterface

// File: rtl/rv32c_fetch_aligner.sv
// RV32C fetch aligner: word-aligned imem reads realigned into a 3-halfword
// parcel buffer, presenting one 16- or 32-bit instruction per handshake.
module rv32c_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic                  CLK,
    input  logic                  nRST,
    rv32c_fetch_aligner_if.master bus
);
    localparam int unsigned HW_W  = 16;
    localparam int unsigned BUF_W = 3 * HW_W;
    localparam int unsigned XLEN  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              drop_low_q, drop_low_d;

    logic [HW_W-1:0]   head_c;
    logic              head_is_c;
    logic              valid_c;
    logic [1:0]        pop_n;
    logic [1:0]        cnt_pop;
    logic [1:0]        app_n;
    logic [XLEN-1:0]   app_data;
    logic [BUF_W-1:0]  shifted;
    logic [BUF_W-1:0]  appended;

    // Presentation is decoded from registered buffer state only.
    assign head_c    = buf_q[HW_W-1:0];
    assign head_is_c = (head_c[1:0] != 2'b11);
    assign valid_c   = head_is_c ? (cnt_q != 2'd0) : (cnt_q >= 2'd2);

    assign bus.inst_valid = valid_c;
    assign bus.inst_is_c  = valid_c & head_is_c;
    assign bus.inst_out   = !valid_c  ? '0 :
                            head_is_c ? {16'h0, head_c} : buf_q[2*HW_W-1:0];
    assign bus.inst_pc    = inst_pc_q;
    assign bus.imem_req   = (state_q != IDLE);
    assign bus.imem_addr  = addr_q;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        fetch_pc_d = fetch_pc_q;
        inst_pc_d  = inst_pc_q;
        addr_d     = addr_q;
        drop_low_d = drop_low_q;
        pop_n      = 2'd0;
        app_n      = 2'd0;
        app_data   = '0;

        if (valid_c && !bus.stall && !bus.redirect) begin
            pop_n = head_is_c ? 2'd1 : 2'd2;
        end
        cnt_pop = cnt_q - pop_n;

        case (pop_n)
            2'd1:    shifted = {16'h0, buf_q[BUF_W-1:HW_W]};
            2'd2:    shifted = {32'h0, buf_q[BUF_W-1:2*HW_W]};
            default: shifted = buf_q;
        endcase

        // A refill only lands when at most one halfword survives the pop.
        if (state_q == WAIT && bus.imem_ack) begin
            app_n    = drop_low_q ? 2'd1 : 2'd2;
            app_data = drop_low_q ? {16'h0, bus.imem_rdata[31:16]} : bus.imem_rdata;
        end
        appended = cnt_pop[0] ? {app_data, 16'h0} : {16'h0, app_data};

        if (bus.redirect) begin
            cnt_d      = 2'd0;
            buf_d      = '0;
            inst_pc_d  = bus.redirect_pc & 32'hFFFF_FFFE;
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            drop_low_d = bus.redirect_pc[1];
            if ((state_q == WAIT || state_q == DISCARD) && !bus.imem_ack) begin
                state_d = DISCARD;
            end else begin
                state_d = IDLE;
            end
        end else begin
            buf_d     = shifted | appended;
            cnt_d     = cnt_pop + app_n;
            inst_pc_d = inst_pc_q + XLEN'({pop_n, 1'b0});
            case (state_q)
                IDLE: begin
                    if (cnt_pop <= 2'd1) begin
                        state_d = WAIT;
                        addr_d  = fetch_pc_q;
                    end
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        drop_low_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
                DISCARD: begin
                    if (bus.imem_ack) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            cnt_q      <= 2'd0;
            fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
            inst_pc_q  <= RESET_PC & 32'hFFFF_FFFE;
            addr_q     <= RESET_PC & 32'hFFFF_FFFC;
            drop_low_q <= RESET_PC[1];
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            fetch_pc_q <= fetch_pc_d;
            inst_pc_q  <= inst_pc_d;
            addr_q     <= addr_d;
            drop_low_q <= drop_low_d;
        end
    end
endmodule

// File: tb/tb_rv32c_fetch_aligner.sv
// Directed bench for rv32c_fetch_aligner: a latency-programmable memory model
// feeds the fetch port while hand-computed instruction streams are checked.
module tb_rv32c_fetch_aligner;
    logic clk;
    logic nRST;

    rv32c_fetch_aligner_if bus ();

    rv32c_fetch_aligner #(.RESET_PC(32'h0000_0200)) dut (
        .CLK  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [512];
    int          lat      = 0;
    bit          mem_hold = 0;
    int          wcnt     = 0;
    bit          pending  = 0;
    logic [31:0] prev_addr     = '0;
    logic [31:0] last_ack_addr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: acks after 'lat' waiting cycles, checks address hold.
    always @(negedge clk) begin
        if (!nRST) begin
            bus.imem_ack = 1'b0;
            wcnt         = 0;
            pending      = 1'b0;
        end else begin
            if (pending && bus.imem_req) check("addr_stable", bus.imem_addr, prev_addr);
            if (bus.imem_req && !mem_hold && wcnt == lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem[bus.imem_addr[10:2]];
                last_ack_addr  = bus.imem_addr;
                wcnt           = 0;
                pending        = 1'b0;
            end else if (bus.imem_req) begin
                bus.imem_ack = 1'b0;
                wcnt++;
                pending   = 1'b1;
                prev_addr = bus.imem_addr;
            end else begin
                bus.imem_ack = 1'b0;
                wcnt         = 0;
                pending      = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset(input string tag);
        nRST            = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.stall       = 1'b0;
        step();
        step();
        check({tag, "_rst_req"},   32'(bus.imem_req),   32'd0);
        check({tag, "_rst_valid"}, 32'(bus.inst_valid), 32'd0);
        check({tag, "_rst_out"},   bus.inst_out,        32'd0);
        check({tag, "_rst_isc"},   32'(bus.inst_is_c),  32'd0);
        check({tag, "_rst_pc"},    bus.inst_pc,         32'h200);
        nRST = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.inst_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
    endtask

    task automatic expect_inst(input string tag, input logic [31:0] e_out,
                               input logic e_c, input logic [31:0] e_pc);
        wait_valid(tag);
        check({tag, "_out"}, bus.inst_out,       e_out);
        check({tag, "_isc"}, 32'(bus.inst_is_c), 32'(e_c));
        check({tag, "_pc"},  bus.inst_pc,        e_pc);
        step();
    endtask

    initial begin
        int n;
        nRST            = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.stall       = 1'b0;

        // Zero-wait first fetch and exact latency.
        clear_mem();
        mem[32'h200 >> 2] = 32'h0000_4501;
        lat = 0;
        do_reset("a");
        step();
        check("a_req_c1",   32'(bus.imem_req),   32'd1);
        check("a_addr_c1",  bus.imem_addr,       32'h200);
        check("a_valid_c1", 32'(bus.inst_valid), 32'd0);
        step();
        check("a_valid_c2", 32'(bus.inst_valid), 32'd1);
        check("a_isc_c2",   32'(bus.inst_is_c),  32'd1);
        check("a_out_c2",   bus.inst_out,        32'h0000_4501);
        check("a_pc_c2",    bus.inst_pc,         32'h200);
        step();
        check("a_out_c3",   bus.inst_out,        32'h0);
        check("a_isc_c3",   32'(bus.inst_is_c),  32'd1);
        check("a_pc_c3",    bus.inst_pc,         32'h202);

        // 32-bit instruction straddling two words.
        clear_mem();
        mem[32'h200 >> 2] = 32'h0093_4501;
        mem[32'h204 >> 2] = 32'hABCD_0010;
        lat = 2;
        do_reset("b");
        expect_inst("b_c0", 32'h0000_4501, 1'b1, 32'h200);
        wait_valid("b_w");
        check("b_ack_before_present", last_ack_addr, 32'h204);
        expect_inst("b_i32", 32'h0010_0093, 1'b0, 32'h202);
        expect_inst("b_c1",  32'h0000_ABCD, 1'b1, 32'h206);

        // Redirect while a request is pending: stale data discarded.
        clear_mem();
        mem[32'h200 >> 2] = 32'h1111_1111;
        mem[32'h304 >> 2] = 32'h4105_8888;
        mem[32'h308 >> 2] = 32'h0000_0001;
        lat = 3;
        do_reset("c");
        step();
        check("c_req", 32'(bus.imem_req), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0306;
        step();
        bus.redirect = 1'b0;
        check("c_disc_req",   32'(bus.imem_req),   32'd1);
        check("c_disc_addr",  bus.imem_addr,       32'h200);
        check("c_disc_valid", 32'(bus.inst_valid), 32'd0);
        wait_valid("c_w");
        check("c_refetch_addr", last_ack_addr, 32'h304);
        expect_inst("c_hi",   32'h0000_4105, 1'b1, 32'h306);
        expect_inst("c_next", 32'h0000_0001, 1'b1, 32'h308);

        // Stall with a full buffer holds the presentation and fetch.
        clear_mem();
        mem[32'h200 >> 2] = 32'h0093_4501;
        mem[32'h204 >> 2] = 32'hABCD_0010;
        mem[32'h208 >> 2] = 32'h0000_0002;
        lat = 0;
        do_reset("d");
        expect_inst("d_c0", 32'h0000_4501, 1'b1, 32'h200);
        bus.stall = 1'b1;
        wait_valid("d_w");
        for (int i = 0; i < 5; i++) begin
            check("d_stall_out", bus.inst_out,      32'h0010_0093);
            check("d_stall_pc",  bus.inst_pc,       32'h202);
            check("d_stall_req", 32'(bus.imem_req), 32'd0);
            step();
        end
        bus.stall = 1'b0;
        expect_inst("d_i32", 32'h0010_0093, 1'b0, 32'h202);
        expect_inst("d_c1",  32'h0000_ABCD, 1'b1, 32'h206);
        expect_inst("d_c2",  32'h0000_0002, 1'b1, 32'h208);

        // Redirect coinciding with ack and a would-be consume.
        clear_mem();
        mem[32'h200 >> 2] = 32'h4501_7777;
        mem[32'h204 >> 2] = 32'h0000_0009;
        mem[32'h400 >> 2] = 32'h0000_0005;
        lat = 1;
        do_reset("e");
        bus.stall = 1'b1;
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0202;
        step();
        bus.redirect = 1'b0;
        wait_valid("e_w");
        check("e_out", bus.inst_out, 32'h0000_4501);
        check("e_pc",  bus.inst_pc,  32'h202);
        n = 0;
        while (!bus.imem_ack && n < 20) begin
            step();
            n++;
        end
        check("e_ack_seen", 32'(bus.imem_ack), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0400;
        bus.stall       = 1'b0;
        step();
        bus.redirect = 1'b0;
        check("e_valid_after", 32'(bus.inst_valid), 32'd0);
        check("e_pc_after",    bus.inst_pc,         32'h400);
        check("e_req_after",   32'(bus.imem_req),   32'd0);
        expect_inst("e_tgt", 32'h0000_0005, 1'b1, 32'h400);

        // Reset in the middle of an outstanding request.
        clear_mem();
        mem[32'h200 >> 2] = 32'h0000_4501;
        mem_hold = 1'b1;
        lat      = 0;
        do_reset("f");
        step();
        check("f_req_wait", 32'(bus.imem_req), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check("f_req_async", 32'(bus.imem_req), 32'd0);
        mem_hold = 1'b0;
        step();
        step();
        nRST = 1'b1;
        step();
        check("f_req_restart",  32'(bus.imem_req), 32'd1);
        check("f_addr_restart", bus.imem_addr,     32'h200);
        expect_inst("f_c0", 32'h0000_4501, 1'b1, 32'h200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
